// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked execute-stage ALU with condition codes and iterative multiply
module alu_exec_unit #(
  parameter int BIT_WID = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         ALUfun,
  input  logic [BIT_WID-1:0] ALUA,
  input  logic [BIT_WID-1:0] ALUB,
  input  logic               set_cond,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_WID-1:0] valE,
  output logic [3:0]         CC,
  output logic               busy
);

  localparam int SH_WID = $clog2(BIT_WID);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BIT_WID-1:0]       vale_q, vale_d;
  logic [3:0]               cc_q, cc_d;
  logic [2*BIT_WID-1:0]     acc_q, acc_d;
  logic [2*BIT_WID-1:0]     mcand_q, mcand_d;
  logic [BIT_WID-1:0]       mplier_q, mplier_d;
  logic [SH_WID-1:0]        cnt_q, cnt_d;
  logic                     msc_q, msc_d;

  logic                     accept;
  logic [BIT_WID-1:0]       alu_res;
  logic [3:0]               alu_cc;
  logic [BIT_WID:0]         sum_x;
  logic [BIT_WID:0]         dif_x;
  logic [SH_WID-1:0]        sh_amt;
  logic [2*BIT_WID-1:0]     acc_step;
  logic [BIT_WID-1:0]       mul_lo;
  logic                     mul_hi_nz;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign valE      = vale_q;
  assign CC        = cc_q;

  // Single-cycle operations and their flags; flag order is {CF, OF, SF, ZF}
  always_comb begin
    sum_x   = {1'b0, ALUB} + {1'b0, ALUA};
    dif_x   = {1'b0, ALUB} - {1'b0, ALUA};
    sh_amt  = ALUA[SH_WID-1:0];
    alu_res = '0;
    alu_cc  = 4'b0000;
    case (ALUfun)
      OP_ADD: begin
        alu_res   = sum_x[BIT_WID-1:0];
        alu_cc[3] = sum_x[BIT_WID];
        alu_cc[2] = (ALUA[BIT_WID-1] == ALUB[BIT_WID-1]) &&
                    (alu_res[BIT_WID-1] != ALUB[BIT_WID-1]);
      end
      OP_SUB: begin
        alu_res   = dif_x[BIT_WID-1:0];
        alu_cc[3] = dif_x[BIT_WID];
        alu_cc[2] = (ALUA[BIT_WID-1] != ALUB[BIT_WID-1]) &&
                    (alu_res[BIT_WID-1] != ALUB[BIT_WID-1]);
      end
      OP_AND:  alu_res = ALUB & ALUA;
      OP_OR:   alu_res = ALUB | ALUA;
      OP_XOR:  alu_res = ALUB ^ ALUA;
      OP_SHL:  alu_res = ALUB << sh_amt;
      OP_SHR:  alu_res = ALUB >> sh_amt;
      default: alu_res = '0;
    endcase
    alu_cc[1] = alu_res[BIT_WID-1];
    alu_cc[0] = (alu_res == '0);
  end

  // One radix-2 shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_lo    = acc_step[BIT_WID-1:0];
    mul_hi_nz = |acc_step[2*BIT_WID-1:BIT_WID];
  end

  // Next-state logic: accept/retire handshake, multiply iteration and result/flag writeback
  always_comb begin
    state_d  = state_q;
    vale_d   = vale_q;
    cc_d     = cc_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    msc_d    = msc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (ALUfun == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{BIT_WID{1'b0}}, ALUB};
            mplier_d = ALUA;
            cnt_d    = '0;
            msc_d    = set_cond;
            state_d  = S_MUL;
          end else begin
            vale_d  = alu_res;
            if (set_cond) begin
              cc_d = alu_cc;
            end
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH_WID'(1);
        if (cnt_q == SH_WID'(BIT_WID - 1)) begin
          vale_d = mul_lo;
          if (msc_q) begin
            cc_d = {mul_hi_nz, mul_hi_nz, mul_lo[BIT_WID-1], (mul_lo == '0)};
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vale_q   <= '0;
      cc_q     <= 4'b0000;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      msc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vale_q   <= vale_d;
      cc_q     <= cc_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      msc_q    <= msc_d;
    end
  end

endmodule
